multicycle_control_unit: RTL and testbench

Sequenced control unit for the BUBBLE core that replaces the single-cycle combinational decoder with an FSM. It accepts one instruction per handshake and steps it through execute, optional data-memory access, and writeback. Data memory uses a req/ack handshake, so the memory may stall for any number of cycles. It sits between the instruction source, the register file, the ALU and data memory, and keeps a retired-instruction counter.

---
 rtl/multicycle_control_unit_pkg.sv | 26 ++
 rtl/multicycle_control_unit_if.sv | 47 ++++
 rtl/multicycle_control_unit_decoder.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the BUBBLE multicycle control unit: opcode constants,
// instruction classes and FSM states.
package cu_pkg;

    localparam logic [5:0] OP_LOAD       = 6'd12;
    localparam logic [5:0] OP_STORE      = 6'd13;
    localparam logic [5:0] OP_BCOND_LO   = 6'd14;
    localparam logic [5:0] OP_BCOND_HI   = 6'd19;
    localparam logic [5:0] OP_J          = 6'd20;
    localparam logic [5:0] OP_JR         = 6'd21;
    localparam logic [5:0] OP_JAL        = 6'd22;
    localparam logic [5:0] OP_LAST_LEGAL = 6'd24;

    typedef enum logic [2:0] {
        IMM_ALU, REG_ALU, LOAD, STORE, BCOND, JUMP, JAL, ILLEGAL
    } cu_class_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } cu_state_e;

    function automatic logic is_imm_op(input logic [5:0] op);
        return op inside {6'd4, 6'd5, [6'd8:6'd11], 6'd24};
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle of instruction, register-file, ALU and data-memory signals around
// the control unit. master = control unit side, slave = environment side.
interface multicycle_control_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] regin1;
    logic [DATA_W-1:0] regin2;
    logic [DATA_W-1:0] aluout1;
    logic [DATA_W-1:0] aluout2;
    logic [DATA_W-1:0] aluin;
    logic              branch_cond;
    logic              branch;
    logic [DATA_W-1:0] offset;
    logic              write_enable;
    logic [DATA_W-1:0] regout;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_base;
    logic [DATA_W-1:0] dmem_offset;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              busy;
    logic [CNT_W-1:0]  retire_cnt;
    logic              trap;

    modport master (
        input  instr_valid, instruction, regin1, regin2, aluin, branch_cond,
               dmem_ack, dmem_rdata,
        output instr_ready, aluout1, aluout2, branch, offset, write_enable,
               regout, dmem_req, dmem_we, dmem_base, dmem_offset, dmem_wdata,
               busy, retire_cnt, trap
    );

    modport slave (
        output instr_valid, instruction, regin1, regin2, aluin, branch_cond,
               dmem_ack, dmem_rdata,
        input  instr_ready, aluout1, aluout2, branch, offset, write_enable,
               regout, dmem_req, dmem_we, dmem_base, dmem_offset, dmem_wdata,
               busy, retire_cnt, trap
    );

endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// Opcode-to-class decoder. With CU_ILLEGAL_TRAP_EN, opcodes above the last
// legal one decode as ILLEGAL; otherwise they fall into REG_ALU.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] opcode_i,
    output cu_class_e  cls_o,
    output logic       needs_mem_o,
    output logic       writes_reg_o,
    output logic       is_redirect_o
);

    always_comb begin
        cls_o = REG_ALU;
        if (is_imm_op(opcode_i)) begin
            cls_o = IMM_ALU;
        end else if (opcode_i == OP_LOAD) begin
            cls_o = LOAD;
        end else if (opcode_i == OP_STORE) begin
            cls_o = STORE;
        end else if (opcode_i >= OP_BCOND_LO && opcode_i <= OP_BCOND_HI) begin
            cls_o = BCOND;
        end else if (opcode_i == OP_J || opcode_i == OP_JR) begin
            cls_o = JUMP;
        end else if (opcode_i == OP_JAL) begin
            cls_o = JAL;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        else if (opcode_i > OP_LAST_LEGAL) begin
            cls_o = ILLEGAL;
        end
`endif
    end

    assign needs_mem_o   = (cls_o == LOAD) || (cls_o == STORE);
    assign writes_reg_o  = (cls_o == IMM_ALU) || (cls_o == REG_ALU) ||
                           (cls_o == LOAD) || (cls_o == JAL);
    assign is_redirect_o = (cls_o == BCOND) || (cls_o == JUMP) || (cls_o == JAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the BUBBLE core: FSM, operand latches and the
// retired-instruction counter. Optional illegal-opcode trap: CU_ILLEGAL_TRAP_EN.
//
//   state   | meaning
//   IDLE    | ready for an instruction
//   EXEC    | drive ALU operands / redirect, latch results
//   MEM     | data-memory request held until ack
//   WB      | register-file write
//   TRAP    | illegal opcode seen, frozen until reset
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BOFF_W = 11,
    parameter int JOFF_W = 21,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_unit_if.master bus
);

    cu_state_e         state_q;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] r1_q;
    logic [DATA_W-1:0] r2_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    cu_class_e cls;
    logic      needs_mem;
    logic      writes_reg;
    logic      is_redirect;

    cu_decoder u_dec (
        .opcode_i      (instr_q[31:26]),
        .cls_o         (cls),
        .needs_mem_o   (needs_mem),
        .writes_reg_o  (writes_reg),
        .is_redirect_o (is_redirect)
    );

    logic [5:0]        op;
    logic [DATA_W-1:0] imm16_ext;
    logic [DATA_W-1:0] boff_ext;
    logic [DATA_W-1:0] joff_ext;
    logic              unused_instr_bits;

    assign op                = instr_q[31:26];
    assign imm16_ext         = {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    assign boff_ext          = {{(DATA_W-BOFF_W){1'b0}}, instr_q[BOFF_W-1:0]};
    assign joff_ext          = {{(DATA_W-JOFF_W){1'b0}}, instr_q[JOFF_W-1:0]};
    assign unused_instr_bits = ^instr_q[25:JOFF_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            alu_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instruction;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_q <= bus.aluin;
                    r1_q  <= bus.regin1;
                    r2_q  <= bus.regin2;
                    if (needs_mem) begin
                        state_q <= ST_MEM;
                    end else if (writes_reg) begin
                        state_q <= ST_WB;
                    end
`ifdef CU_ILLEGAL_TRAP_EN
                    else if (cls == ILLEGAL) begin
                        state_q <= ST_TRAP;
                    end
`endif
                    else begin
                        state_q <= ST_IDLE;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_MEM: begin
                    // ack ends the request; anything before it is a stall
                    if (bus.dmem_ack) begin
                        if (cls == LOAD) begin
                            rdata_q <= bus.dmem_rdata;
                            state_q <= ST_WB;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
`ifdef CU_ILLEGAL_TRAP_EN
                ST_TRAP: state_q <= ST_TRAP;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.instr_ready  = (state_q == ST_IDLE);
        bus.busy         = (state_q != ST_IDLE);
        bus.retire_cnt   = cnt_q;
        bus.aluout1      = '0;
        bus.aluout2      = '0;
        bus.branch       = 1'b0;
        bus.offset       = '0;
        bus.write_enable = 1'b0;
        bus.regout       = '0;
        bus.dmem_req     = 1'b0;
        bus.dmem_we      = 1'b0;
        bus.dmem_base    = '0;
        bus.dmem_offset  = '0;
        bus.dmem_wdata   = '0;
        case (state_q)
            ST_EXEC: begin
                bus.aluout1 = bus.regin1;
                bus.aluout2 = (cls == IMM_ALU) ? imm16_ext : bus.regin2;
                if (is_redirect) begin
                    bus.branch = (cls == BCOND) ? bus.branch_cond : 1'b1;
                end
                if (op == OP_JR) begin
                    bus.offset = bus.regin1;
                end else if (op == OP_J || op == OP_JAL) begin
                    bus.offset = joff_ext;
                end else if (cls == BCOND) begin
                    bus.offset = boff_ext;
                end
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                if (cls == STORE) begin
                    bus.dmem_we     = 1'b1;
                    bus.dmem_base   = r2_q;
                    bus.dmem_offset = boff_ext;
                    bus.dmem_wdata  = r1_q;
                end else begin
                    bus.dmem_base   = r1_q;
                    bus.dmem_offset = imm16_ext;
                end
            end
            ST_WB: begin
                bus.write_enable = 1'b1;
                bus.regout       = (cls == LOAD) ? rdata_q : alu_q;
            end
            default: ;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.trap = (state_q == ST_TRAP);
`else
    assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; expectations are hand-computed.
module tb_multicycle_control_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] instr);
        bus.instruction = instr;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.regin1      = '0;
        bus.regin2      = '0;
        bus.aluin       = '0;
        bus.branch_cond = 1'b0;
        bus.dmem_ack    = 1'b0;
        bus.dmem_rdata  = '0;
        #2;
        chk("rst_ready",  32'(bus.instr_ready), 32'd1);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_cnt",    32'(bus.retire_cnt), 32'd0);
        chk("rst_req",    32'(bus.dmem_req), 32'd0);
        chk("rst_we",     32'(bus.write_enable), 32'd0);
        chk("rst_branch", 32'(bus.branch), 32'd0);
        chk("rst_trap",   32'(bus.trap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // immediate ALU, opcode 4
        bus.regin1 = 32'd5;
        bus.regin2 = 32'd7;
        bus.aluin  = 32'h104;
        accept({6'd4, 10'd0, 16'h00FF});
        chk("imm_busy",    32'(bus.busy), 32'd1);
        chk("imm_ready",   32'(bus.instr_ready), 32'd0);
        chk("imm_aluout1", bus.aluout1, 32'd5);
        chk("imm_aluout2", bus.aluout2, 32'h0000_00FF);
        chk("imm_nowe",    32'(bus.write_enable), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instruction = {6'd13, 26'd0};
        tick();
        bus.instr_valid = 1'b0;
        bus.aluin = 32'h999;
        chk("imm_we",     32'(bus.write_enable), 32'd1);
        chk("imm_regout", bus.regout, 32'h104);
        chk("imm_nobr",   32'(bus.branch), 32'd0);
        tick();
        chk("imm_ready2", 32'(bus.instr_ready), 32'd1);
        chk("imm_cnt",    32'(bus.retire_cnt), 32'd1);
        chk("imm_we_off", 32'(bus.write_enable), 32'd0);

        // load with 4-cycle stall; ack during EXEC must be ignored
        bus.regin1 = 32'h1000;
        accept({6'd12, 10'd0, 16'h0010});
        bus.dmem_ack = 1'b1;
        bus.regin1   = 32'h7777;
        tick();
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = 32'hDEAD_BEEF;
            end
            chk("ld_req",  32'(bus.dmem_req), 32'd1);
            chk("ld_we",   32'(bus.dmem_we), 32'd0);
            tick();
        end
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        chk("ld_req_off", 32'(bus.dmem_req), 32'd0);
        chk("ld_wb_we",   32'(bus.write_enable), 32'd1);
        chk("ld_regout",  bus.regout, 32'hDEAD_BEEF);
        tick();
        chk("ld_ready", 32'(bus.instr_ready), 32'd1);
        chk("ld_cnt",   32'(bus.retire_cnt), 32'd2);

        // load addressing observed separately in a second short load
        bus.regin1 = 32'h3000;
        accept({6'd12, 10'd0, 16'h0010});
        tick();
        chk("ld_base", bus.dmem_base, 32'h3000);
        chk("ld_off",  bus.dmem_offset, 32'h10);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        tick();
        chk("ld2_cnt", 32'(bus.retire_cnt), 32'd3);

        // store, ack in first MEM cycle, offset field truncated to 11 bits
        bus.regin1 = 32'hA5;
        bus.regin2 = 32'h200;
        accept({6'd13, 10'd0, 16'hF923});
        chk("st_aluout2", bus.aluout2, 32'h200);
        tick();
        bus.dmem_ack = 1'b1;
        chk("st_req",   32'(bus.dmem_req), 32'd1);
        chk("st_we",    32'(bus.dmem_we), 32'd1);
        chk("st_wdata", bus.dmem_wdata, 32'hA5);
        chk("st_base",  bus.dmem_base, 32'h200);
        chk("st_off",   bus.dmem_offset, 32'h123);
        chk("st_nowe",  32'(bus.write_enable), 32'd0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("st_ready", 32'(bus.instr_ready), 32'd1);
        chk("st_nowe2", 32'(bus.write_enable), 32'd0);
        chk("st_cnt",   32'(bus.retire_cnt), 32'd4);

        // conditional branch, not taken then taken
        bus.branch_cond = 1'b0;
        accept({6'd15, 10'd0, 16'hFABC});
        chk("bc0_branch", 32'(bus.branch), 32'd0);
        tick();
        chk("bc0_ready", 32'(bus.instr_ready), 32'd1);
        chk("bc0_cnt",   32'(bus.retire_cnt), 32'd5);
        bus.branch_cond = 1'b1;
        accept({6'd15, 10'd0, 16'hFABC});
        chk("bc1_branch", 32'(bus.branch), 32'd1);
        chk("bc1_offset", bus.offset, 32'h2BC);
        chk("bc1_nowe",   32'(bus.write_enable), 32'd0);
        tick();
        bus.branch_cond = 1'b0;
        chk("bc1_pulse", 32'(bus.branch), 32'd0);
        chk("bc1_cnt",   32'(bus.retire_cnt), 32'd6);

        // register jump, target from regin1
        bus.regin1 = 32'h40;
        accept({6'd21, 26'h3FF_FFFF});
        chk("jr_branch", 32'(bus.branch), 32'd1);
        chk("jr_offset", bus.offset, 32'h40);
        tick();
        chk("jr_ready", 32'(bus.instr_ready), 32'd1);
        chk("jr_cnt",   32'(bus.retire_cnt), 32'd7);

        // jump-and-link: redirect in EXEC, write in WB
        bus.aluin = 32'h77;
        accept({6'd22, 26'h3FF_FFFF});
        chk("jal_branch", 32'(bus.branch), 32'd1);
        chk("jal_offset", bus.offset, 32'h001F_FFFF);
        chk("jal_nowe",   32'(bus.write_enable), 32'd0);
        tick();
        chk("jal_we",     32'(bus.write_enable), 32'd1);
        chk("jal_nobr",   32'(bus.branch), 32'd0);
        chk("jal_regout", bus.regout, 32'h77);
        tick();
        chk("jal_cnt", 32'(bus.retire_cnt), 32'd8);

        // reset in the third stalled MEM cycle of a load
        bus.regin1 = 32'h500;
        accept({6'd12, 10'd0, 16'h0004});
        tick();
        tick();
        tick();
        chk("rm_req_pre", 32'(bus.dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_req",  32'(bus.dmem_req), 32'd0);
        chk("rm_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rm_ready", 32'(bus.instr_ready), 32'd1);
        chk("rm_cnt",   32'(bus.retire_cnt), 32'd0);

        // opcode 40
        bus.aluin = 32'h1234;
        accept({6'd40, 26'd0});
        chk("il_branch", 32'(bus.branch), 32'd0);
        tick();
`ifdef CU_ILLEGAL_TRAP_EN
        chk("il_trap",  32'(bus.trap), 32'd1);
        chk("il_busy",  32'(bus.busy), 32'd1);
        chk("il_nowe",  32'(bus.write_enable), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instruction = {6'd4, 26'd0};
        tick();
        tick();
        bus.instr_valid = 1'b0;
        chk("il_hold",  32'(bus.trap), 32'd1);
        chk("il_ready", 32'(bus.instr_ready), 32'd0);
        chk("il_cnt",   32'(bus.retire_cnt), 32'd0);
`else
        chk("il_trap",   32'(bus.trap), 32'd0);
        chk("il_we",     32'(bus.write_enable), 32'd1);
        chk("il_regout", bus.regout, 32'h1234);
        tick();
        chk("il_ready", 32'(bus.instr_ready), 32'd1);
        chk("il_cnt",   32'(bus.retire_cnt), 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("fin_trap",  32'(bus.trap), 32'd0);
        chk("fin_ready", 32'(bus.instr_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
